conv3x3_engine: RTL

// - Pipelined 3x3 convolution for the image-filter path: 9 pixels in, one filtered pixel out.
// - Generalises the fixed-kernel convolver with these additions:
//   - runtime-programmable signed kernel;
//   - programmable right-shift normaliser with clamp/abs output modes;
//   - downstream backpressure;
//   - parametrised widths.
// - Sits between the line-buffer window generator and the output pixel FIFO.

---
 rtl/conv3x3_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_engine.sv
// ---------------------------------------------------------------------------
// conv3x3_engine
//
// Pipelined 3x3 convolution for the image-filter path. Takes a 9-pixel window
// from the line-buffer window generator and produces one filtered pixel for
// the output pixel FIFO.
//
// Features:
//   - Runtime-programmable signed 3x3 kernel.
//   - Programmable arithmetic right-shift normaliser.
//   - Clamp or abs-then-clamp output modes.
//   - Downstream backpressure.
//
// Pipeline (every stage advances only while i_ready=1):
//   - S1: 9 signed products.
//   - S2: signed sum of the products.
//   - S3: shift, mode and clamp; output registers.
//
// Optional build macro:
//   CONV_ROUND_EN - round half up before the shift. When undefined the shift
//                   truncates toward -inf and no rounding adder is built.
//
// Ports:
//   i_clk                   clock, rising edge
//   i_rst                   asynchronous reset, active-high
//   i_pixel_data            window; pixel k at [k*PIX_W +: PIX_W], k=0 top-left
//   i_pixel_data_valid      window valid, accepted when o_ready=1
//   o_ready                 upstream may present data (follows i_ready)
//   i_ready                 downstream accepts output
//   i_mode                  0 = clamp, 1 = |sum| then clamp
//   i_coef_wr               coefficient/config write strobe
//   i_coef_addr             0..8 kernel[k], 9 shift amount, 10..15 ignored
//   i_coef_data             write data
//   o_convolved_data        filtered pixel
//   o_convolved_data_valid  output valid
//   o_sum                   raw signed sum before the shift, aligned with output
// ---------------------------------------------------------------------------
module conv3x3_engine #(
  parameter  int PIX_W  = 8,
  parameter  int COEF_W = 8,
  localparam int PROD_W = PIX_W + COEF_W + 1,
  localparam int SUM_W  = PROD_W + 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [9*PIX_W-1:0]      i_pixel_data,
  input  logic                    i_pixel_data_valid,
  output logic                    o_ready,
  input  logic                    i_ready,
  input  logic                    i_mode,
  input  logic                    i_coef_wr,
  input  logic [3:0]              i_coef_addr,
  input  logic [COEF_W-1:0]       i_coef_data,
  output logic [PIX_W-1:0]        o_convolved_data,
  output logic                    o_convolved_data_valid,
  output logic signed [SUM_W-1:0] o_sum
);

  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  logic signed [COEF_W-1:0] kernel [9];
  logic [3:0]               shift;

  // Backpressure is passed straight through: a frozen pipeline cannot accept.
  assign o_ready = i_ready;

  // ---------------------------------------------------------------------------
  // Configuration registers. Writes are independent of i_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: this small register file is reset on purpose, because the
      // kernel must come back as a known Laplacian. Large data memories would
      // normally be left without a reset.
      for (int k = 0; k < 9; k++)
        kernel[k] <= (k == 4) ? COEF_W'(8) : {COEF_W{1'b1}};
      shift <= '0;
    end else if (i_coef_wr) begin
      for (int k = 0; k < 9; k++)
        if (i_coef_addr == 4'(k)) kernel[k] <= i_coef_data;
      if (i_coef_addr == 4'd9) shift <= i_coef_data[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S1: products.
  // The coefficient is sign-extended and the pixel is zero-extended to
  // PROD_W, which holds the full product including -2^(COEF_W-1) x max pixel.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_c [9];
  logic signed [PROD_W-1:0] prod_r [9];
  logic                     v1;

  always_comb begin
    for (int k = 0; k < 9; k++)
      prod_c[k] = PROD_W'(kernel[k]) *
                  $signed(PROD_W'(i_pixel_data[k*PIX_W +: PIX_W]));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1 <= 1'b0;
      for (int k = 0; k < 9; k++) prod_r[k] <= '0;
    end else if (i_ready) begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // samples the previous stage's value from before this edge.
      v1 <= i_pixel_data_valid;
      for (int k = 0; k < 9; k++) prod_r[k] <= prod_c[k];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: exact sum of all nine products.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] sum_r;
  logic                    v2;

  always_comb begin
    // NOTE: every combinational output gets a default first, which prevents
    // latch inference on any path.
    sum_c = '0;
    for (int k = 0; k < 9; k++) sum_c = sum_c + SUM_W'(prod_r[k]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2    <= 1'b0;
      sum_r <= '0;
    end else if (i_ready) begin
      v2    <= v1;
      sum_r <= sum_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: normalise, mode, clamp. Shift and mode are the live values here.
  // SUM_W has ample headroom, so the rounding addend cannot overflow.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] pre_shift;
  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] mag;
  logic [PIX_W-1:0]        pix_c;

`ifdef CONV_ROUND_EN
  logic signed [SUM_W-1:0] round_add;

  always_comb begin
    round_add = '0;
    if (shift != 4'd0) round_add[shift - 4'd1] = 1'b1;
    pre_shift = sum_r + round_add;
  end
`else
  assign pre_shift = sum_r;
`endif

  always_comb begin
    shifted = pre_shift >>> shift;
    mag     = (i_mode && shifted < 0) ? -shifted : shifted;
    if (mag < 0)
      pix_c = '0;
    else if (mag > PIX_MAX)
      pix_c = PIX_MAX[PIX_W-1:0];
    else
      pix_c = mag[PIX_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_convolved_data_valid <= 1'b0;
      o_convolved_data       <= '0;
      o_sum                  <= '0;
    end else if (i_ready) begin
      o_convolved_data_valid <= v2;
      o_convolved_data       <= pix_c;
      o_sum                  <= sum_r;
    end
  end

endmodule
